// File: rtl/id_pkg.sv
// Shared opcode, ALU-op and control definitions for the RISC-V decode stage.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Unknown opcodes decode to an all-zero NOP control word.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_R:      c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT};
            OP_IMM:    c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT};
            OP_LOAD:   c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OP_ADD};
            OP_STORE:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OP_ADD};
            OP_BRANCH: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_SUB};
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register file: two combinational read ports with write-through
// bypass from the single write-back port; x0 is hardwired to zero.
module gp_regfile #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREG];

    // NOTE: the array is reset so operands are never X after reset; this rules
    // out a RAM macro, which is acceptable for a 32-entry flop file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != '0) rs1_data = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != '0) rs2_data = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register read, immediate generation, control decode,
// load-use hazard detection and a single valid/ready output slot.
module id_stage
    import id_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RAW-1:0]  out_rd,
    output logic [1:0]      out_alu_op,
    output logic            out_alu_src,
    output logic            out_branch,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            out_reg_write
);

    logic [6:0]      opcode;
    logic [RAW-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic signed [31:0] imm32;
    ctrl_t           ctrl, slot_ctrl;
    logic            rs2_used, hazard, advance;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[7 +: RAW];
    assign rs1    = in_inst[15 +: RAW];
    assign rs2    = in_inst[20 +: RAW];
    assign ctrl   = decode_ctrl(opcode);

    gp_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            OP_STORE:
                imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            OP_BRANCH:
                imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {in_inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Signed cast carries inst[31] up to the full datapath width.
    assign imm = XLEN'(imm32);

    assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign hazard   = out_valid && slot_ctrl.mem_read && out_rd != '0 &&
                      (out_rd == rs1 || (rs2_used && out_rd == rs2));
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && (!hazard || flush);

    // Bubbles only drop valid; payload keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            slot_ctrl    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance && in_valid && !hazard) begin
            out_valid    <= 1'b1;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_imm      <= imm;
            out_rd       <= rd;
            slot_ctrl    <= ctrl;
        end else if (advance) begin
            out_valid <= 1'b0;
        end
    end

    assign out_alu_op     = slot_ctrl.alu_op;
    assign out_alu_src    = slot_ctrl.alu_src;
    assign out_branch     = slot_ctrl.branch;
    assign out_mem_read   = slot_ctrl.mem_read;
    assign out_mem_write  = slot_ctrl.mem_write;
    assign out_mem_to_reg = slot_ctrl.mem_to_reg;
    assign out_reg_write  = slot_ctrl.reg_write;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a default 64-bit/32-register instance plus a
// 32-bit/16-register instance for the narrow-datapath branch immediate.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance (XLEN=64, NREG=32)
    logic        in_valid = 1'b0, in_ready, wb_en = 1'b0, flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] in_inst = '0;
    logic [4:0]  wb_rd = '0, out_rd;
    logic [63:0] wb_data = '0, out_rs1_data, out_rs2_data, out_imm;
    logic [1:0]  out_alu_op;
    logic        out_alu_src, out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rd(out_rd), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write)
    );

    // Narrow instance (XLEN=32, NREG=16)
    logic        n_in_valid = 1'b0, n_in_ready, n_out_valid;
    logic [31:0] n_in_inst = '0, n_rs1_data, n_rs2_data, n_imm;
    logic [3:0]  n_rd;
    logic [1:0]  n_alu_op;
    logic        n_alu_src, n_branch, n_mem_read, n_mem_write, n_mem_to_reg, n_reg_write;

    id_stage #(.XLEN(32), .NREG(16)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_inst(n_in_inst),
        .wb_en(1'b0), .wb_rd(4'd0), .wb_data(32'd0), .flush(1'b0),
        .out_valid(n_out_valid), .out_ready(1'b1),
        .out_rs1_data(n_rs1_data), .out_rs2_data(n_rs2_data), .out_imm(n_imm),
        .out_rd(n_rd), .out_alu_op(n_alu_op), .out_alu_src(n_alu_src),
        .out_branch(n_branch), .out_mem_read(n_mem_read), .out_mem_write(n_mem_write),
        .out_mem_to_reg(n_mem_to_reg), .out_reg_write(n_reg_write)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm", out_imm, 64'd0);
        check("rst_reg_write", 64'(out_reg_write), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Load x1=5, x2=22 through write-back
        tick();
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd5;
        tick();
        wb_rd = 5'd2; wb_data = 64'd22;
        tick();
        wb_en = 1'b0;

        // add x3,x1,x2; narrow instance decodes beq x1,x2,-4 in parallel
        issue(32'h0020_81B3);
        n_in_valid = 1'b1; n_in_inst = 32'hFE20_8EE3;
        #1;
        check("add_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_rs1", out_rs1_data, 64'd5);
        check("add_rs2", out_rs2_data, 64'd22);
        check("add_alu_op", 64'(out_alu_op), 64'd2);
        check("add_reg_write", 64'(out_reg_write), 64'd1);
        check("add_rd", 64'(out_rd), 64'd3);
        check("beq32_imm", 64'(n_imm), 64'h0000_0000_FFFF_FFFC);
        check("beq32_branch", 64'(n_branch), 64'd1);
        check("beq32_alu_op", 64'(n_alu_op), 64'd1);
        check("beq32_reg_write", 64'(n_reg_write), 64'd0);
        n_in_valid = 1'b0;

        // ld x5,-8(x1)
        issue(32'hFF80_B283);
        tick();
        check("ld_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ld_mem_read", 64'(out_mem_read), 64'd1);
        check("ld_mem_to_reg", 64'(out_mem_to_reg), 64'd1);
        check("ld_alu_src", 64'(out_alu_src), 64'd1);
        check("ld_rd", 64'(out_rd), 64'd5);

        // add x6,x5,x2 depends on the load: one refused cycle, one bubble
        issue(32'h0022_8333);
        #1;
        check("lu_in_ready_block", 64'(in_ready), 64'd0);
        tick();
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_in_ready_clear", 64'(in_ready), 64'd1);
        tick();
        check("lu_add_valid", 64'(out_valid), 64'd1);
        check("lu_add_rd", 64'(out_rd), 64'd6);
        check("lu_add_rs2", out_rs2_data, 64'd22);
        check("lu_add_mem_read", 64'(out_mem_read), 64'd0);

        // Bypass: addi x8,x7,0 while x7 is written back the same cycle
        issue(32'h0003_8413);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hABCD;
        tick();
        check("bypass_rs1", out_rs1_data, 64'hABCD);
        check("bypass_alu_src", 64'(out_alu_src), 64'd1);
        // addi x9,x7,0 now reads the updated array
        wb_en = 1'b0;
        issue(32'h0003_8493);
        tick();
        check("array_rs1", out_rs1_data, 64'hABCD);
        // add x10,x0,x0 with a write-back aimed at x0
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234;
        issue(32'h0000_0533);
        tick();
        check("x0_rs1", out_rs1_data, 64'd0);
        check("x0_rs2", out_rs2_data, 64'd0);
        wb_en = 1'b0;

        // lui x11,0x80000: sign-extended U immediate, NOP controls
        issue(32'h8000_05B7);
        tick();
        check("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_reg_write", 64'(out_reg_write), 64'd0);

        // sd x2,16(x1), then stall 3 cycles with a new instruction waiting
        issue(32'h0020_B823);
        tick();
        check("sd_imm", out_imm, 64'd16);
        check("sd_mem_write", 64'(out_mem_write), 64'd1);
        out_ready = 1'b0;
        issue(32'h0020_81B3);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd99;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_in_ready_%0d", i), 64'(in_ready), 64'd0);
            tick();
            check($sformatf("hold_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("hold_imm_%0d", i), out_imm, 64'd16);
            check($sformatf("hold_rs1_%0d", i), out_rs1_data, 64'd5);
        end
        wb_en = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        out_ready = 1'b1;

        // add x3,x1,x2 sees x1=99, then reset mid-cycle clears slot and array
        issue(32'h0020_81B3);
        tick();
        check("post_flush_rs1", out_rs1_data, 64'd99);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_rs1", out_rs1_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0020_81B3);
        tick();
        check("after_rst_rs1", out_rs1_data, 64'd0);
        check("after_rst_rs2", out_rs2_data, 64'd0);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
